// File: rtl/cv32e40px_irq_pender.sv
// rtl/cv32e40px_irq_pender.sv - interrupt source synchronizer, edge latching and pending/overflow tracking
// Optional 2-stage input synchronizer selected by CV32E40PX_IRQ_SYNC_EN.
module cv32e40px_irq_pender #(
   parameter logic [31:0] EDGE_MASK = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] irq_src_i,
   input  logic        irq_ack_i,
   input  logic [4:0]  irq_id_i,
   input  logic [31:0] sw_clr_i,
   output logic [31:0] irq_o,
   output logic [31:0] irq_ovf_o
);

   logic [31:0] sync_q;
   logic [31:0] prev_q, prev_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] ovf_q,  ovf_d;
   logic [31:0] edge_det;
   logic [31:0] ack_vec;
   logic [31:0] clr_vec;

`ifdef CV32E40PX_IRQ_SYNC_EN
   logic [31:0] meta_q, meta_d;
   logic [31:0] sync_d;

   always_comb begin
      meta_d = irq_src_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end
`else
   assign sync_q = irq_src_i;
`endif

   // A new edge always wins over a same-cycle clear so no interrupt is lost;
   // overflow is only flagged when the edge lands on a pending bit that is not being cleared.
   always_comb begin
      prev_d   = sync_q;
      ack_vec  = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;
      clr_vec  = ack_vec | sw_clr_i;
      edge_det = sync_q & ~prev_q & EDGE_MASK;
      pend_d   = (edge_det | (pend_q & ~clr_vec)) & EDGE_MASK;
      ovf_d    = ((edge_det & pend_q & ~clr_vec) | (ovf_q & ~sw_clr_i)) & EDGE_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         pend_q <= '0;
         ovf_q  <= '0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign irq_o     = (pend_q & EDGE_MASK) | (sync_q & ~EDGE_MASK);
   assign irq_ovf_o = ovf_q;

endmodule

// File: tb/tb_cv32e40px_irq_pender.sv
// tb/tb_cv32e40px_irq_pender.sv - self-checking bench for cv32e40px_irq_pender against a delayed-source reference model
module tb_cv32e40px_irq_pender;

   localparam logic [31:0] MASK = 32'hFFFF_0000;
`ifdef CV32E40PX_IRQ_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] irq_src_i = '0;
   logic        irq_ack_i = 1'b0;
   logic [4:0]  irq_id_i = '0;
   logic [31:0] sw_clr_i = '0;
   logic [31:0] irq_o;
   logic [31:0] irq_ovf_o;

   int total = 0;
   int bad = 0;

   // reference model state: history of source values seen at each clock edge
   logic [31:0] hist[$];
   logic [31:0] m_pend = '0;
   logic [31:0] m_ovf = '0;
   logic [31:0] m_sync_prev = '0;
   logic [31:0] m_lvl = '0;

   cv32e40px_irq_pender #(.EDGE_MASK(MASK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_src_i (irq_src_i),
      .irq_ack_i (irq_ack_i),
      .irq_id_i  (irq_id_i),
      .sw_clr_i  (sw_clr_i),
      .irq_o     (irq_o),
      .irq_ovf_o (irq_ovf_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] hist_at(input int k);
      if (k < 0 || k >= hist.size()) return 32'd0;
      return hist[k];
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_pend = '0;
      m_ovf = '0;
      m_sync_prev = '0;
      m_lvl = '0;
   endtask

   // The synchronized source used at edge n is the raw source seen D edges earlier.
   task automatic model_edge(input logic [31:0] src, input logic ack, input logic [4:0] id,
                             input logic [31:0] clr);
      int n;
      logic [31:0] s, e;
      logic c;
      hist.push_back(src);
      n = hist.size() - 1;
      s = hist_at(n - D);
      e = s & ~m_sync_prev & MASK;
      for (int i = 0; i < 32; i++) begin
         if (MASK[i]) begin
            c = (ack && (int'(id) == i)) || clr[i];
            if (e[i] && m_pend[i] && !c) m_ovf[i] = 1'b1;
            else if (clr[i])             m_ovf[i] = 1'b0;
            if (e[i])   m_pend[i] = 1'b1;
            else if (c) m_pend[i] = 1'b0;
         end
      end
      m_sync_prev = s;
      m_lvl = (D == 0) ? src : hist_at(n + 1 - D);
   endtask

   task automatic step(input logic [31:0] src, input logic ack, input logic [4:0] id,
                       input logic [31:0] clr);
      irq_src_i = src;
      irq_ack_i = ack;
      irq_id_i  = id;
      sw_clr_i  = clr;
      @(posedge clk);
      model_edge(src, ack, id, clr);
      #1;
      chk32("irq_o", irq_o, (m_pend & MASK) | (m_lvl & ~MASK));
      chk32("irq_ovf_o", irq_ovf_o, m_ovf);
   endtask

   task automatic idle(input logic [31:0] src, input int cnt);
      for (int k = 0; k < cnt; k++) step(src, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] base;
      logic [31:0] rsrc;
      logic [31:0] rclr;

      // reset state, then release with line 16 already high
      rst_n = 1'b0;
      irq_src_i = 32'h0001_0000;
      #12;
      chk32("reset_irq", irq_o, 32'h0);
      chk32("reset_ovf", irq_ovf_o, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      base = 32'h0001_0000;
      idle(base, 4);
      chk32("held_at_reset", irq_o, 32'h0001_0000);

      // single pulse on line 20, acknowledged later
      step(base | 32'h0010_0000, 1'b0, 5'd0, 32'd0);
      idle(base, 4);
      chk1("pend20_before_ack", irq_o[20], 1'b1);
      step(base, 1'b1, 5'd20, 32'd0);
      chk1("pend20_after_ack", irq_o[20], 1'b0);
      chk1("ovf20_clean", irq_ovf_o[20], 1'b0);

      // two pulses on line 20 while pending -> overflow, ack keeps it, sw clear drops it
      step(base | 32'h0010_0000, 1'b0, 5'd0, 32'd0);
      idle(base, 4);
      step(base | 32'h0010_0000, 1'b0, 5'd0, 32'd0);
      idle(base, 4);
      chk1("ovf20_set", irq_ovf_o[20], 1'b1);
      step(base, 1'b1, 5'd20, 32'd0);
      chk1("irq20_acked", irq_o[20], 1'b0);
      chk1("ovf20_survives_ack", irq_ovf_o[20], 1'b1);
      step(base, 1'b0, 5'd0, 32'h0010_0000);
      chk1("ovf20_swclr", irq_ovf_o[20], 1'b0);

      // line 25: new edge reaches detect together with an ack of 25
      step(base | 32'h0200_0000, 1'b0, 5'd0, 32'd0);
      idle(base, D + 2);
      for (int k = 0; k <= D; k++)
         step((k == 0) ? (base | 32'h0200_0000) : base, k == D, 5'd25, 32'd0);
      chk1("irq25_set_beats_ack", irq_o[25], 1'b1);
      chk1("ovf25_none", irq_ovf_o[25], 1'b0);
      idle(base, 2);

      // level line 11 ignores ack and follows the source
      idle(base | 32'h0000_0800, 4);
      step(base | 32'h0000_0800, 1'b1, 5'd11, 32'h0000_0800);
      chk1("lvl11_ignores_ack", irq_o[11], 1'b1);
      idle(base | 32'h0000_0800, 2);
      idle(base, 4);
      chk1("lvl11_released", irq_o[11], 1'b0);

      // randomized traffic against the model
      rsrc = base;
      for (int k = 0; k < 400; k++) begin
         rsrc = rsrc ^ ($urandom() & $urandom() & $urandom());
         rclr = ($urandom_range(0, 5) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
         if ($urandom_range(0, 40) == 0) rclr = $urandom();
         step(rsrc, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), rclr);
      end

      // drain, clear everything, then build pending+overflow on lines 16..31
      idle(32'h0, D + 2);
      step(32'h0, 1'b0, 5'd0, 32'hFFFF_FFFF);
      chk32("drained", irq_o | irq_ovf_o, 32'h0);
      idle(32'hFFFF_0000, D + 2);
      idle(32'h0, D + 2);
      idle(32'hFFFF_0000, D + 2);
      idle(32'h0, 1);
      chk32("all_ovf", irq_ovf_o, 32'hFFFF_0000);
      chk32("all_pend", irq_o, 32'hFFFF_0000);

      // asynchronous reset mid-cycle
      #3;
      rst_n = 1'b0;
      #1;
      chk32("async_rst_irq", irq_o, 32'h0);
      chk32("async_rst_ovf", irq_ovf_o, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(32'h0, 2);
      idle(32'h0040_0800, D + 3);
      idle(32'h0, D + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
